// File: rtl/puzzle_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : puzzle_input_ctrl
// Brief    : Front-panel input block for the puzzle board game. Scans a 4x4
//            active-low keypad (each press toggles one dot), debounces four
//            cursor buttons (area inc/dec/home, dot clear) and drives the
//            status LEDs.
// Revision : 1.0 - initial release
// ============================================================================
module puzzle_input_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        finish,
  input  logic        switch,
  input  logic [3:0]  keycol,
  input  logic [3:0]  button,
  output logic [3:0]  keyrow,
  output logic [2:0]  area,
  output logic [15:0] dot,
  output logic [7:0]  led
);

  localparam int             C_CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(SCAN_DIV - 1);

  // Synchronizer stages (idle level is 1 = released)
  logic [3:0]         r_keycol_meta;
  logic [3:0]         r_keycol_sync;
  logic [3:0]         r_button_meta;
  logic [3:0]         r_button_sync;

  // Scan timing
  logic [C_CNT_W-1:0] r_count;
  logic [1:0]         r_row;
  logic               w_tick;

  // Press history: 1 = key was pressed at its last sample
  logic [15:0]        r_hist;
  // Previous tick sample of the buttons (1 = released)
  logic [3:0]         r_btn_prev;

  // Registered outputs
  logic [2:0]         r_area;
  logic [15:0]        r_dot;
  logic [7:0]         r_led;

  // Derived per-tick quantities
  logic [3:0]         w_shift;
  logic [3:0]         w_row_pressed;
  logic [3:0]         w_row_hist;
  logic [3:0]         w_row_event;
  logic [15:0]        w_toggle;
  logic [15:0]        w_row_mask;
  logic [15:0]        w_row_new;
  logic [3:0]         w_btn_event;
  logic               w_enable;

  assign w_tick        = (r_count == C_CNT_LAST);
  assign w_enable      = switch & ~finish;
  assign w_shift       = {r_row, 2'b00};
  assign w_row_pressed = ~r_keycol_sync;
  assign w_row_hist    = r_hist[w_shift +: 4];
  assign w_row_event   = w_row_pressed & ~w_row_hist;
  assign w_toggle      = {12'h000, w_row_event} << w_shift;
  assign w_row_mask    = 16'h000F << w_shift;
  assign w_row_new     = {12'h000, w_row_pressed} << w_shift;
  assign w_btn_event   = r_btn_prev & ~r_button_sync;

  assign keyrow = ~(4'b0001 << r_row);
  assign area   = r_area;
  assign dot    = r_dot;
  assign led    = r_led;

  // Two-flop synchronizers for keypad columns and buttons
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_keycol_meta <= 4'hF;
      r_keycol_sync <= 4'hF;
      r_button_meta <= 4'hF;
      r_button_sync <= 4'hF;
    end else begin
      r_keycol_meta <= keycol;
      r_keycol_sync <= r_keycol_meta;
      r_button_meta <= button;
      r_button_sync <= r_button_meta;
    end
  end

  // Scan prescaler and row pointer; row advances after its sample tick
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_row   <= 2'd0;
    end else if (w_tick) begin
      r_count <= '0;
      r_row   <= r_row + 2'd1;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // History tracks key/button state regardless of switch/finish so that a
  // key held across an enable change never produces a late event
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hist     <= 16'h0000;
      r_btn_prev <= 4'hF;
    end else if (w_tick) begin
      r_hist     <= (r_hist & ~w_row_mask) | w_row_new;
      r_btn_prev <= r_button_sync;
    end
  end

  // Cursor area: home beats increment beats decrement, one change per tick
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_area <= 3'd0;
    end else if (w_tick && w_enable) begin
      if (w_btn_event[2]) begin
        r_area <= 3'd0;
      end else if (w_btn_event[0]) begin
        r_area <= r_area + 3'd1;
      end else if (w_btn_event[1]) begin
        r_area <= r_area - 3'd1;
      end
    end
  end

  // Dot pattern: clear button overrides any keypad toggles in the same tick
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dot <= 16'h0000;
    end else if (w_tick && w_enable) begin
      if (w_btn_event[3]) begin
        r_dot <= 16'h0000;
      end else begin
        r_dot <= r_dot ^ w_toggle;
      end
    end
  end

  // Status LEDs: all on when finished, off when disabled, else one-hot area
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_led <= 8'h00;
    end else if (finish) begin
      r_led <= 8'hFF;
    end else if (!switch) begin
      r_led <= 8'h00;
    end else begin
      r_led <= 8'h01 << r_area;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_puzzle_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_puzzle_input_ctrl
// Brief    : Directed self-checking bench for puzzle_input_ctrl with a
//            behavioural 4x4 keypad model and SCAN_DIV = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_puzzle_input_ctrl;

  localparam int SCAN_DIV = 4;

  logic        clock;
  logic        reset;
  logic        finish;
  logic        switch;
  logic [3:0]  keycol;
  logic [3:0]  button;
  logic [3:0]  keyrow;
  logic [2:0]  area;
  logic [15:0] dot;
  logic [7:0]  led;

  // Keys currently held, bit r*4+c
  logic [15:0] keys;

  int compared;
  int mismatched;

  puzzle_input_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clock  (clock),
    .reset  (reset),
    .finish (finish),
    .switch (switch),
    .keycol (keycol),
    .button (button),
    .keyrow (keyrow),
    .area   (area),
    .dot    (dot),
    .led    (led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad model: a held key pulls its column low while its row is driven
  always_comb begin
    keycol = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!keyrow[r] && keys[r*4+c]) keycol[c] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp)
      else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  // Hold a key for several full scan rounds, then release and let it rearm
  task automatic tap_key(input int k);
    keys[k] = 1'b1;
    cycles(40);
    keys[k] = 1'b0;
    cycles(40);
  endtask

  // Hold a button well over two ticks, then release for over two ticks
  task automatic tap_button(input int b);
    button[b] = 1'b0;
    cycles(12);
    button[b] = 1'b1;
    cycles(12);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset  = 1'b0;
    finish = 1'b0;
    switch = 1'b1;
    button = 4'hF;
    keys   = 16'h0000;

    // Reset state
    cycles(3);
    check("rst_keyrow", {12'h0, keyrow}, 16'h000E);
    check("rst_area",   {13'h0, area},   16'h0000);
    check("rst_dot",    dot,             16'h0000);
    check("rst_led",    {8'h0, led},     16'h0000);

    // Release reset; LED shows area 0 after one edge, rows advance every 4
    reset = 1'b1;
    cycles(1);
    check("led_after_rst", {8'h0, led}, 16'h0001);
    cycles(3);
    check("row1", {12'h0, keyrow}, 16'h000D);
    cycles(4);
    check("row2", {12'h0, keyrow}, 16'h000B);
    cycles(4);
    check("row3", {12'h0, keyrow}, 16'h0007);
    cycles(4);
    check("row0_wrap", {12'h0, keyrow}, 16'h000E);

    // Held key toggles exactly once; second press toggles back
    keys[6] = 1'b1;
    cycles(48);
    check("key6_press", dot, 16'h0040);
    cycles(48);
    check("key6_held", dot, 16'h0040);
    keys[6] = 1'b0;
    cycles(40);
    check("key6_release", dot, 16'h0040);
    tap_key(6);
    check("key6_again", dot, 16'h0000);

    // Two keys on the same row toggle together
    keys[4] = 1'b1;
    keys[7] = 1'b1;
    cycles(40);
    keys = 16'h0000;
    cycles(40);
    check("row1_multi", dot, 16'h0090);
    tap_key(4);
    tap_key(7);
    check("row1_clear", dot, 16'h0000);

    // Area increment with wrap, LED tracks
    for (int i = 1; i <= 8; i++) begin
      tap_button(0);
      check("area_inc", {13'h0, area}, 16'(i % 8));
      check("led_inc",  {8'h0, led},   16'(8'h01 << (i % 8)));
    end
    tap_button(1);
    check("area_dec_wrap", {13'h0, area}, 16'h0007);
    check("led_dec_wrap",  {8'h0, led},   16'h0080);

    // Disabled: presses ignored, LEDs off
    switch = 1'b0;
    cycles(2);
    check("led_sw0", {8'h0, led}, 16'h0000);
    tap_key(0);
    tap_button(0);
    tap_button(2);
    check("dot_sw0",  dot,             16'h0000);
    check("area_sw0", {13'h0, area},   16'h0007);
    switch = 1'b1;
    cycles(2);
    check("led_sw1", {8'h0, led}, 16'h0080);

    // Finished: LEDs all on, presses ignored
    finish = 1'b1;
    cycles(2);
    check("led_fin", {8'h0, led}, 16'h00FF);
    tap_key(5);
    tap_button(1);
    check("dot_fin",  dot,           16'h0000);
    check("area_fin", {13'h0, area}, 16'h0007);

    // Key held across finish falling produces no event
    keys[9] = 1'b1;
    cycles(40);
    finish = 1'b0;
    cycles(40);
    check("held_across_fin", dot, 16'h0000);
    keys[9] = 1'b0;
    cycles(40);

    // Corner keys, then clear button
    tap_key(0);
    tap_key(15);
    check("dot_corners", dot, 16'h8001);
    tap_button(3);
    check("dot_clear", dot, 16'h0000);

    // Home button returns area to 0
    tap_button(2);
    check("area_home", {13'h0, area}, 16'h0000);

    // Rebuild dot=8001, area=5 then reset asynchronously mid-cycle
    tap_key(0);
    tap_key(15);
    for (int i = 0; i < 5; i++) tap_button(0);
    check("pre_rst_dot",  dot,           16'h8001);
    check("pre_rst_area", {13'h0, area}, 16'h0005);
    #2;
    reset = 1'b0;
    #1;
    check("async_keyrow", {12'h0, keyrow}, 16'h000E);
    check("async_area",   {13'h0, area},   16'h0000);
    check("async_dot",    dot,             16'h0000);
    check("async_led",    {8'h0, led},     16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/puzzle_input_ctrl.md
Name: puzzle_input_ctrl

Overview:
- Front-panel input/indicator block for the puzzle board game.
- Scans a 4x4 matrix keypad; each key press toggles one cell of a 16-bit dot pattern.
- Debounces four push-buttons that move a 3-bit area cursor.
- Drives 8 status LEDs from the cursor and game state.
- Outputs area and dot feed the dot-matrix display driver; finish and switch come from top-level game control.

Parameters:
- SCAN_DIV, 50000, clock cycles per scan tick (keypad row period and button sample period); minimum 2.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- finish  input  1  game-complete flag; 1 freezes area and dot.
- switch  input  1  play enable; 0 ignores keypad/button presses.
- keycol  input  4  keypad column sense, active-low (0 = key pressed on driven row).
- button  input  4  push-buttons, active-low.
- keyrow  output  4  keypad row drive, active-low, one row low at a time.
- area  output  3  cursor area index 0..7.
- dot  output  16  dot pattern; bit r*4+c = key at row r, column c.
- led  output  8  status LEDs.

Behaviour:
- Reset (reset=0, async): prescaler=0, row index=0, keyrow=4'b1110, area=0, dot=16'h0000, led=8'h00, all press-history bits=released, synchronizers=released (1).
- Synchronization: keycol and button each pass through a 2-FF synchronizer before use.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick=1 for the one cycle when count==SCAN_DIV-1.
- Keypad scan:
  - Row index r (0..3) is driven as keyrow = ~(4'b0001<<r).
  - On tick: sample the synchronized keycol for current row r, then advance r (3 wraps to 0).
  - The row therefore stays stable for SCAN_DIV cycles before sampling.
  - Keep 16 history bits, one per key, storing its last sampled pressed state. Only the 4 bits of the scanned row update per tick.
  - Press event for key k=r*4+c: sampled pressed (keycol[c]==0) and history[k]==released.
  - Holding a key produces exactly one event; release rearms it.
  - Effect of a press event, only if switch==1 and finish==0: dot[k] toggles.
  - Multiple keys pressed on the same row in one sample all toggle in that cycle.
  - History always updates, even when the event is ignored.
- Buttons:
  - Sampled on tick. Press event when the sampled value is 0 and the previous tick sample was 1.
  - Events are acted on only if switch==1 and finish==0.
  - button[0]: area = area+1 mod 8 (7 -> 0).
  - button[1]: area = area-1 mod 8 (0 -> 7).
  - button[2]: area = 0.
  - button[3]: dot = 16'h0000.
- Simultaneous events:
  - Priority among area buttons: button[2] > button[0] > button[1]; only one area change per tick.
  - button[3] clear beats any keypad toggle in the same tick.
- LEDs (registered, update every cycle):
  - finish==1: led = 8'hFF.
  - else switch==0: led = 8'h00.
  - else: led = 8'h01 << area (one-hot).
- switch toggled mid-operation: area and dot hold their values; scanning continues.
- finish==1: scanning continues, area and dot hold, history still tracks key/button state.
  - A key held across finish falling does not generate a new event.
- Reset mid-scan: immediate return to reset state.
- Latency:
  - A stable press is visible on dot/area at most 4*SCAN_DIV+3 cycles after the key is applied.
  - led follows area one cycle later.

Test Plan:
- Reset with switch=1, SCAN_DIV=4: keyrow=4'b1110, area=0, dot=0; one cycle after reset release led=8'h01. Rows cycle 1110→1101→1011→0111 every 4 clocks.
- Hold key row1/col2 (keycol[2]=0 when keyrow=1101) for 3 full scan rounds: dot=16'h0040 exactly once. Release, press again: dot=16'h0000.
- Press button[0] 8 times (each held ≥2 ticks, released ≥2 ticks): area goes 1..7 then 0; led one-hot tracks area. Then button[1] once: area=7, led=8'h80.
- switch=0: key and button presses leave dot/area unchanged, led=8'h00. Return switch=1: led shows held area.
- finish=1: led=8'hFF, key presses ignored. Press button[3] with finish=0 after setting dots: dot=16'h0000.
- Assert reset while dot=16'h8001, area=5: outputs return to reset values immediately, without waiting for a clock edge.
